// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared SHA-256 sequencing types and constants
package sha256_pkg;

    // Compression rounds per 512-bit block
    localparam int SHA256_ROUNDS = 64;

    // Rounds whose W word comes straight from the message block
    localparam int MSG_ROUNDS = 16;

    // Width of a SHA-256 word and of each K constant
    localparam int SHA256_WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREFETCH = 2'd1,
        ST_ROUND    = 2'd2,
        ST_FINAL    = 2'd3
    } seq_state_t;

endpackage

// File: rtl/sha256_round_sequencer.sv
// rtl/sha256_round_sequencer.sv - round sequencer feeding K constants to the SHA-256 core
module sha256_round_sequencer
    import sha256_pkg::*;
#(
    parameter int ROUNDS = SHA256_ROUNDS,
    parameter int WORD_W = SHA256_WORD_W
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      core_ready,
    input  logic [WORD_W-1:0]         rom_data,
    output logic [$clog2(ROUNDS)-1:0] rom_addr,
    output logic [WORD_W-1:0]         k_out,
    output logic                      k_valid,
    output logic [$clog2(ROUNDS)-1:0] round_idx,
    output logic                      w_from_msg,
    output logic                      init_hash,
    output logic                      final_add,
    output logic                      busy,
    output logic                      done
);

    localparam int                IDX_W    = $clog2(ROUNDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);
    localparam logic [IDX_W-1:0] MSG_IDX  = IDX_W'(MSG_ROUNDS);

    seq_state_t state;
    seq_state_t state_nxt;

    logic handshake;
    logic last_round;

    // A round is consumed when it is presented and the core takes it
    assign handshake  = k_valid & core_ready;
    assign last_round = (round_idx == LAST_IDX);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; abort wins over every other condition
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:     if (start) state_nxt = ST_PREFETCH;
                ST_PREFETCH: state_nxt = ST_ROUND;
                ST_ROUND:    if (handshake && last_round) state_nxt = ST_FINAL;
                ST_FINAL:    state_nxt = ST_IDLE;
                default:     state_nxt = ST_IDLE;
            endcase
        end
    end

    // Round counter and K register: load K0 leaving PREFETCH, then advance on each handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_out     <= '0;
            round_idx <= '0;
            k_valid   <= 1'b0;
        end else if (abort) begin
            k_valid <= 1'b0;
        end else begin
            case (state)
                ST_PREFETCH: begin
                    k_out     <= rom_data;
                    round_idx <= '0;
                    k_valid   <= 1'b1;
                end
                ST_ROUND: begin
                    if (handshake) begin
                        if (last_round) begin
                            k_valid <= 1'b0;
                        end else begin
                            round_idx <= round_idx + IDX_W'(1);
                            k_out     <= rom_data;
                        end
                    end
                end
                default: begin
                    k_valid <= 1'b0;
                end
            endcase
        end
    end

    // ROM address points one round ahead so the next K is ready at the handshake edge
    always_comb begin
        rom_addr = '0;
        if (state == ST_ROUND && !last_round) begin
            rom_addr = round_idx + IDX_W'(1);
        end
    end

    assign busy       = (state != ST_IDLE);
    assign init_hash  = (state == ST_PREFETCH);
    assign final_add  = (state == ST_FINAL);
    assign done       = (state == ST_FINAL);
    assign w_from_msg = (round_idx < MSG_IDX);

endmodule

// File: tb/tb_sha256_round_sequencer.sv
// tb/tb_sha256_round_sequencer.sv - self-checking bench for the SHA-256 round sequencer
module tb_sha256_round_sequencer;

    localparam int ROUNDS = 64;
    localparam int IDX_W  = 6;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic             core_ready;
    logic [31:0]      rom_data;
    logic [IDX_W-1:0] rom_addr;
    logic [31:0]      k_out;
    logic             k_valid;
    logic [IDX_W-1:0] round_idx;
    logic             w_from_msg;
    logic             init_hash;
    logic             final_add;
    logic             busy;
    logic             done;

    logic [31:0] k_tab [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // External asynchronous constant ROM
    assign rom_data = k_tab[rom_addr];

    sha256_round_sequencer #(.ROUNDS(ROUNDS), .WORD_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .core_ready (core_ready),
        .rom_data   (rom_data),
        .rom_addr   (rom_addr),
        .k_out      (k_out),
        .k_valid    (k_valid),
        .round_idx  (round_idx),
        .w_from_msg (w_from_msg),
        .init_hash  (init_hash),
        .final_add  (final_add),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Per-block observations
    int          busy_cnt, init_cnt, done_cnt, done_cyc, first_kv_cyc;
    int          fin_bad, hold_bad, stall_cnt, stall_left, stall_i;
    logic [31:0] stall_k;
    logic [31:0] obs_k [$];
    int          obs_i [$];
    bit          obs_w [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run one block from IDLE; mode 0 ready tied high, 1 directed stall, 2 random stalls
    task automatic run_block(input int mode, input int stall_at, input int stall_len, input bit poke);
        logic [31:0] pk;
        int          pi;
        int          cyc;
        bit          was_stall;
        busy_cnt = 0; init_cnt = 0; done_cnt = 0; done_cyc = 0; first_kv_cyc = 0;
        fin_bad = 0; hold_bad = 0; stall_cnt = 0; stall_left = stall_len;
        stall_k = '0; stall_i = -1;
        obs_k.delete(); obs_i.delete(); obs_w.delete();
        pk = '0; pi = 0; was_stall = 1'b0;
        core_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 1;
        while (cyc < 400) begin
            if (!busy) break;
            busy_cnt++;
            if (init_hash) init_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (final_add !== done) fin_bad++;
            if (k_valid && first_kv_cyc == 0) first_kv_cyc = cyc;
            if (was_stall && (k_out !== pk || int'(round_idx) != pi)) hold_bad++;
            case (mode)
                1: begin
                    if (k_valid && int'(round_idx) == stall_at && stall_left > 0) begin
                        core_ready = 1'b0;
                        stall_left--;
                    end else begin
                        core_ready = 1'b1;
                    end
                end
                2:       core_ready = ($urandom_range(0, 3) != 0);
                default: core_ready = 1'b1;
            endcase
            if (poke) start = 1'($urandom_range(0, 1));
            if (k_valid && core_ready) begin
                obs_k.push_back(k_out);
                obs_i.push_back(int'(round_idx));
                obs_w.push_back(w_from_msg);
            end else if (k_valid) begin
                stall_cnt++;
                stall_k = k_out;
                stall_i = int'(round_idx);
            end
            was_stall = k_valid && !core_ready;
            pk = k_out;
            pi = int'(round_idx);
            step();
            cyc++;
        end
        start = 1'b0;
        core_ready = 1'b1;
    endtask

    // Compare a finished block against the reference: K table in order, fixed overhead plus stalls
    task automatic check_block(input string tag, input int exp_stalls);
        int n;
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(ROUNDS + 2 + exp_stalls));
        chk({tag, "_done_cycle"}, 64'(done_cyc), 64'(ROUNDS + 2 + exp_stalls));
        chk({tag, "_first_kvalid"}, 64'(first_kv_cyc), 64'd2);
        chk({tag, "_init_count"}, 64'(init_cnt), 64'd1);
        chk({tag, "_done_count"}, 64'(done_cnt), 64'd1);
        chk({tag, "_final_eq_done"}, 64'(fin_bad), 64'd0);
        chk({tag, "_stall_hold"}, 64'(hold_bad), 64'd0);
        chk({tag, "_round_count"}, 64'(obs_k.size()), 64'(ROUNDS));
        n = (obs_k.size() < ROUNDS) ? obs_k.size() : ROUNDS;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_k%0d", tag, i), 64'(obs_k[i]), 64'(k_tab[i]));
            chk($sformatf("%s_idx%0d", tag, i), 64'(obs_i[i]), 64'(i));
            chk($sformatf("%s_wmsg%0d", tag, i), 64'(obs_w[i]), 64'(i < 16));
        end
    endtask

    // Advance until the presented round reaches target, bounded
    task automatic run_to_round(input int target, input string tag);
        int guard;
        guard = 0;
        while (!(k_valid && int'(round_idx) == target) && guard < 200) begin
            step();
            guard++;
        end
        chk({tag, "_reached"}, 64'(k_valid && int'(round_idx) == target), 64'd1);
    endtask

    initial begin
        int inits, dones, done1, init2, late_done;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; core_ready = 1'b1;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_kvalid", 64'(k_valid), 64'd0);
        chk("rst_kout", 64'(k_out), 64'd0);
        chk("rst_idx", 64'(round_idx), 64'd0);
        chk("rst_addr", 64'(rom_addr), 64'd0);
        chk("rst_pulses", 64'({done, init_hash, final_add}), 64'd0);
        step(); step();
        rst_n = 1'b1;
        step();
        chk("idle_busy", 64'(busy), 64'd0);

        // Nominal block, core always ready
        run_block(0, 0, 0, 1'b0);
        check_block("nominal", 0);
        chk("nominal_idle_after", 64'(busy), 64'd0);

        // Five-cycle stall at round 15
        run_block(1, 15, 5, 1'b0);
        check_block("stall", 5);
        chk("stall_held_k", 64'(stall_k), 64'(k_tab[15]));
        chk("stall_held_idx", 64'(stall_i), 64'd15);
        chk("stall_count", 64'(stall_cnt), 64'd5);

        // Random backpressure
        for (int r = 0; r < 3; r++) begin
            run_block(2, 0, 0, 1'b0);
            check_block($sformatf("rand%0d", r), stall_cnt);
        end

        // Start pulses while busy are ignored
        run_block(2, 0, 0, 1'b1);
        check_block("poke_start", stall_cnt);

        // Abort at round 40
        start = 1'b1; step(); start = 1'b0;
        run_to_round(40, "abort40");
        abort = 1'b1; step(); abort = 1'b0;
        chk("abort40_busy", 64'(busy), 64'd0);
        chk("abort40_kvalid", 64'(k_valid), 64'd0);
        late_done = 0;
        for (int i = 0; i < 70; i++) begin
            if (done || final_add || busy) late_done++;
            step();
        end
        chk("abort40_no_done", 64'(late_done), 64'd0);
        run_block(0, 0, 0, 1'b0);
        check_block("after_abort", 0);

        // Abort during PREFETCH
        start = 1'b1; step(); start = 1'b0;
        chk("pref_init", 64'(init_hash), 64'd1);
        abort = 1'b1; step(); abort = 1'b0;
        chk("pref_abort_busy", 64'(busy), 64'd0);
        chk("pref_abort_init", 64'(init_hash), 64'd0);
        chk("pref_abort_kvalid", 64'(k_valid), 64'd0);

        // Abort beats the final handshake
        start = 1'b1; step(); start = 1'b0;
        run_to_round(ROUNDS - 1, "abortlast");
        abort = 1'b1; step(); abort = 1'b0;
        chk("abortlast_done", 64'({done, final_add}), 64'd0);
        chk("abortlast_busy", 64'(busy), 64'd0);

        // Start and abort together in IDLE
        start = 1'b1; abort = 1'b1; step();
        start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", 64'(busy), 64'd0);
        chk("start_abort_init", 64'(init_hash), 64'd0);

        // Asynchronous reset mid-round, between clock edges
        start = 1'b1; step(); start = 1'b0;
        run_to_round(20, "areset");
        #3;
        rst_n = 1'b0;
        #1;
        chk("areset_busy", 64'(busy), 64'd0);
        chk("areset_kvalid", 64'(k_valid), 64'd0);
        chk("areset_kout", 64'(k_out), 64'd0);
        chk("areset_idx", 64'(round_idx), 64'd0);
        chk("areset_addr", 64'(rom_addr), 64'd0);
        step(); step();
        rst_n = 1'b1;
        late_done = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (busy || done) late_done++;
        end
        chk("areset_stays_idle", 64'(late_done), 64'd0);
        run_block(0, 0, 0, 1'b0);
        check_block("after_reset", 0);

        // Back-to-back blocks with start held high
        inits = 0; dones = 0; done1 = 0; init2 = 0;
        core_ready = 1'b1;
        start = 1'b1;
        for (int c = 1; c <= 133; c++) begin
            step();
            if (init_hash) begin
                inits++;
                if (c > 1) init2 = c;
            end
            if (done) begin
                dones++;
                if (done1 == 0) done1 = c;
            end
            if (c == 133) start = 1'b0;
        end
        step();
        chk("b2b_inits", 64'(inits), 64'd2);
        chk("b2b_dones", 64'(dones), 64'd2);
        chk("b2b_first_done", 64'(done1), 64'(ROUNDS + 2));
        chk("b2b_second_init", 64'(init2), 64'(ROUNDS + 4));
        chk("b2b_idle_end", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
